countdown_ctrl: RTL
===================

Name: countdown_ctrl

Overview:
- Control FSM for the kitchen-timer countdown datapath (BCD minute/second counter driving the 7-seg displays).
- Turns PSW button presses and the RSW preset into counter load/decrement commands, a 1 s tick and an alarm phase.
- Drives BZ and LED and keeps alarm timeout and abort rules in one place so the top level only wires the counter and decoders.

Parameters:
- TICK_DIV, 1000: CLOCK cycles per countdown tick (1 kHz clock gives 1 s).
- BEEP_DIV, 1: CLOCK cycles per BZ toggle while the tone is gated on.
- ALARM_SEC, 10: ticks spent in ALARM before returning automatically to IDLE.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset; the design has one clock.
- PSW_START  in  1  start/pause/resume button, raw level, 1 = pressed.
- PSW_STOP  in  1  stop/abort/silence button, raw level, 1 = pressed.
- RSW  in  4  BCD preset minutes; values above 9 are clamped to 9.
- CNT_ZERO  in  1  from datapath, 1 = counter reads 0:00.
- CNT_LOAD  out  1  one-cycle pulse; the datapath loads CNT_LOAD_MIN:00.
- CNT_LOAD_MIN  out  4  minutes to load, valid while CNT_LOAD = 1.
- CNT_DEC  out  1  one-cycle pulse; the datapath decrements by 1 s.
- STATE  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM.
- LED  out  8  status pattern.
- BZ  out  1  speaker drive, 1 = on.

Behaviour:
- Reset values: all outputs are 0, STATE = IDLE, prescaler = 0, edge registers = 0.
- RESET asserted in any state returns the block to these values on the next edge.
- Edge detect: each button has a previous-value register.
  - start_e = PSW_START & ~prev_start; stop_e likewise.
  - A held button produces one event only.
- Prescaler: counts 0..TICK_DIV-1 only in RUN, holds in PAUSE, clears on IDLE→RUN and in ALARM.
  - tick = (prescaler == TICK_DIV-1) in RUN.
  - In ALARM a separate counter with the same divisor produces ALARM ticks.
- IDLE:
  - start_e with clamped RSW ≠ 0 → RUN. The next cycle (RUN cycle 1) has CNT_LOAD = 1 and CNT_LOAD_MIN = the clamped RSW.
  - start_e with RSW = 0 is ignored. stop_e is ignored.
- RUN:
  - CNT_ZERO is ignored in RUN cycle 1, the load cycle.
  - Priority per cycle: stop_e → IDLE, then CNT_ZERO → ALARM, then start_e → PAUSE, then tick → CNT_DEC = 1 on the following cycle (registered).
  - No CNT_DEC is issued on a cycle in which the state leaves RUN.
- PAUSE:
  - start_e → RUN with no reload and the prescaler kept.
  - stop_e → IDLE. stop_e wins over start_e in the same cycle.
- ALARM:
  - stop_e → IDLE in the next cycle, with BZ = 0 in that cycle.
  - After ALARM_SEC ALARM ticks → IDLE automatically.
  - start_e is ignored.
- BZ:
  - Outside ALARM, BZ = 0.
  - In ALARM, beep_phase toggles on each ALARM tick, starting at 1 on entry.
  - While beep_phase = 1, BZ toggles every BEEP_DIV cycles; while beep_phase = 0, BZ = 0.
- LED:
  - IDLE: 8'h00.
  - RUN: one-hot starting at 8'h01 on entry, rotating left by 1 per tick (8'h80 wraps to 8'h01).
  - PAUSE: frozen at its last value.
  - ALARM: 8'hFF when beep_phase = 1, 8'h00 otherwise.
- Simultaneous start_e and stop_e: stop_e has priority in every state.
- CNT_LOAD and CNT_DEC are never high in the same cycle.

Test Plan (TICK_DIV=4, BEEP_DIV=1, ALARM_SEC=3, with a behavioural BCD counter model):
- Reset, then RSW=1 and a 1-cycle PSW_START pulse → CNT_LOAD=1 and CNT_LOAD_MIN=1 exactly once; STATE=1; CNT_DEC pulses every 4 cycles; after 60 decrements CNT_ZERO=1 → STATE=3 and BZ toggling; no 61st CNT_DEC.
- In ALARM, hold PSW_STOP for 10 cycles → STATE=0 the cycle after the press, BZ=0 and LED=8'h00; no re-trigger during the hold. Then RSW=2 and start → CNT_LOAD_MIN=2.
- ALARM with no stop → after 12 cycles (3 ticks) STATE=0 automatically; BZ gated on/off per tick and LED alternating 8'hFF/8'h00 before exit.
- RUN, press start → STATE=2, CNT_DEC stops and LED frozen; press start again → STATE=1, CNT_DEC resumes, and the first resumed CNT_DEC follows the remaining prescaler count; no CNT_LOAD.
- RSW=0 or RSW=4'hC then start → first is ignored with STATE staying 0; second loads 9.
- Start and stop pressed in the same cycle while in RUN → STATE=0. RESET asserted mid-RUN → all outputs 0 and STATE=0 on the next edge.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Kitchen-timer control FSM: turns START/STOP presses and the RSW preset into
// counter load/decrement pulses, a 1 s tick, and the ALARM buzzer/LED phase.
module countdown_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned BEEP_DIV  = 1,
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PSW_START,
  input  logic       PSW_STOP,
  input  logic [3:0] RSW,
  input  logic       CNT_ZERO,
  output logic       CNT_LOAD,
  output logic [3:0] CNT_LOAD_MIN,
  output logic       CNT_DEC,
  output logic [1:0] STATE,
  output logic [7:0] LED,
  output logic       BZ
);

  localparam int unsigned PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned BW = (BEEP_DIV  > 1) ? $clog2(BEEP_DIV)  : 1;
  localparam int unsigned AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  localparam logic [PW-1:0] TICK_MAX   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_MAX   = BW'(BEEP_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t state, state_nx;

  logic          prev_start, prev_stop;
  logic          start_e, stop_e;
  logic [3:0]    rsw_clamp;
  logic [PW-1:0] run_pre, alarm_pre;
  logic [BW-1:0] beep_pre;
  logic [AW-1:0] alarm_cnt;
  logic          load_q, dec_q;
  logic [3:0]    load_min_q;
  logic [7:0]    led_run;
  logic          beep_phase, bz_q;
  logic          run_tick, alarm_tick;
  logic          load_nx, dec_nx;
  logic          stay_run, stay_alarm;

  assign start_e    = PSW_START & ~prev_start;
  assign stop_e     = PSW_STOP  & ~prev_stop;
  assign rsw_clamp  = (RSW > 4'd9) ? 4'd9 : RSW;
  assign run_tick   = (state == S_RUN)   && (run_pre   == TICK_MAX);
  assign alarm_tick = (state == S_ALARM) && (alarm_pre == TICK_MAX);
  assign stay_run   = (state == S_RUN)   && (state_nx == S_RUN);
  assign stay_alarm = (state == S_ALARM) && (state_nx == S_ALARM);

  always_comb begin
    state_nx = state;
    load_nx  = 1'b0;
    dec_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!stop_e && start_e && (rsw_clamp != 4'd0)) begin
          state_nx = S_RUN;
          load_nx  = 1'b1;
        end
      end
      S_RUN: begin
        // load_q marks RUN cycle 1: CNT_ZERO still reflects the pre-load count
        if (stop_e)                     state_nx = S_IDLE;
        else if (CNT_ZERO && !load_q)   state_nx = S_ALARM;
        else if (start_e)               state_nx = S_PAUSE;
        else if (run_tick)              dec_nx   = 1'b1;
      end
      S_PAUSE: begin
        if (stop_e)       state_nx = S_IDLE;
        else if (start_e) state_nx = S_RUN;
      end
      S_ALARM: begin
        if (stop_e)                                        state_nx = S_IDLE;
        else if (alarm_tick && (alarm_cnt == ALARM_LAST))  state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      prev_start <= 1'b0;
      prev_stop  <= 1'b0;
      load_q     <= 1'b0;
      load_min_q <= '0;
      dec_q      <= 1'b0;
      run_pre    <= '0;
      led_run    <= '0;
      alarm_pre  <= '0;
      alarm_cnt  <= '0;
      beep_phase <= 1'b0;
      beep_pre   <= '0;
      bz_q       <= 1'b0;
    end else begin
      state      <= state_nx;
      prev_start <= PSW_START;
      prev_stop  <= PSW_STOP;
      load_q     <= load_nx;
      load_min_q <= load_nx ? rsw_clamp : 4'd0;
      dec_q      <= dec_nx;

      // Prescaler only advances on cycles that stay in RUN, so a pause keeps
      // the remaining count and no tick is lost on the leaving cycle.
      if (load_nx || (state == S_ALARM))
        run_pre <= '0;
      else if (stay_run)
        run_pre <= run_tick ? '0 : run_pre + 1'b1;

      if (load_nx)
        led_run <= 8'h01;
      else if (dec_nx)
        led_run <= {led_run[6:0], led_run[7]};

      if (stay_alarm) begin
        alarm_pre <= alarm_tick ? '0 : alarm_pre + 1'b1;
        if (alarm_tick) begin
          alarm_cnt  <= alarm_cnt + 1'b1;
          beep_phase <= ~beep_phase;
        end
      end else begin
        alarm_pre  <= '0;
        alarm_cnt  <= '0;
        beep_phase <= (state_nx == S_ALARM);
      end

      // Tone restarts from silence at every ALARM tick boundary.
      if (stay_alarm && beep_phase && !alarm_tick) begin
        if (beep_pre == BEEP_MAX) begin
          beep_pre <= '0;
          bz_q     <= ~bz_q;
        end else begin
          beep_pre <= beep_pre + 1'b1;
        end
      end else begin
        beep_pre <= '0;
        bz_q     <= 1'b0;
      end
    end
  end

  always_comb begin
    LED = '0;
    case (state)
      S_RUN, S_PAUSE: LED = led_run;
      S_ALARM:        LED = beep_phase ? 8'hFF : 8'h00;
      default:        LED = '0;
    endcase
  end

  assign BZ           = (state == S_ALARM) & beep_phase & bz_q;
  assign STATE        = state;
  assign CNT_LOAD     = load_q;
  assign CNT_LOAD_MIN = load_min_q;
  assign CNT_DEC      = dec_q;

endmodule
